// File: rtl/dytr_pkg.sv
// Shared definitions for the dynamic time-redundancy controller: mode codes,
// FSM states and per-mode phase count.
package dytr_pkg;

    localparam logic [1:0] MODE_SIMPLEX = 2'b00;
    localparam logic [1:0] MODE_DUAL    = 2'b01;
    localparam logic [1:0] MODE_TRIPLE  = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StRecover,
        StHalt
    } state_e;

    function automatic logic [1:0] nphases(logic [1:0] mode);
        case (mode)
            MODE_SIMPLEX: return 2'd1;
            MODE_DUAL:    return 2'd2;
            default:      return 2'd3;
        endcase
    endfunction

    // Both upper codes select triple redundancy; only one encoding is stored.
    function automatic logic [1:0] norm_mode(logic [1:0] mode);
        return (mode == 2'b11) ? MODE_TRIPLE : mode;
    endfunction

endpackage

// File: rtl/dytr_sat_cnt.sv
// Saturating up-counter with enable, synchronous clear and async active-low reset.
module dytr_sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/ctr_dyn_tr.sv
// Central control FSM for dynamic time redundancy: sequences 1..3 phases per
// operand and performs rollback-and-retry on detected dual-mode errors.
module ctr_dyn_tr
    import dytr_pkg::*;
#(
    parameter int unsigned NPH      = 3,
    parameter int unsigned RECLEN   = 2,
    parameter int unsigned MAXRETRY = 3,
    parameter int unsigned CNTW     = 8,
    localparam int unsigned PW      = $clog2(NPH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      userMode,
    input  logic            userFetch,
    input  logic            fail,
    output logic            userReady,
    output logic [1:0]      modeS,
    output logic [PW-1:0]   phase,
    output logic            fetchA,
    output logic            recov,
    output logic            userFail,
    output logic [CNTW-1:0] errCnt
);

    localparam int unsigned RW = (MAXRETRY < 1) ? 1 : $clog2(MAXRETRY + 1);
    localparam int unsigned CW = (RECLEN < 2) ? 1 : $clog2(RECLEN);

    state_e        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          ready_q, ready_d;
    logic          fetch_q, fetch_d;
    logic          recov_q, recov_d;
    logic          ufail_q, ufail_d;

    logic          err_inc, retry_inc, retry_clr;
    logic [RW-1:0] retry_q;
    logic [CW-1:0] rec_q;
    logic [PW-1:0] last_ph;
    logic          retry_hit, rec_done, in_rec;

    assign last_ph   = PW'(nphases(mode_q) - 2'd1);
    assign retry_hit = (32'(retry_q) + 32'd1) >= MAXRETRY;
    assign rec_done  = (rec_q == CW'(RECLEN - 1));
    assign in_rec    = (state_q == StRecover);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        phase_d   = phase_q;
        fetch_d   = 1'b0;
        recov_d   = 1'b0;
        ufail_d   = ufail_q;
        err_inc   = 1'b0;
        retry_inc = 1'b0;
        retry_clr = 1'b0;
        unique case (state_q)
            StIdle: begin
                phase_d = '0;
                if (userFetch) begin
                    mode_d  = norm_mode(userMode);
                    state_d = StRun;
                end
            end
            StRun: begin
                if (phase_q != last_ph) begin
                    phase_d = phase_q + PW'(1);
                end else begin
                    phase_d = '0;
                    err_inc = fail;
                    if (fail && (mode_q == MODE_DUAL)) begin
                        // Dual mode cannot correct: roll back, or give up after the retry budget.
                        retry_inc = 1'b1;
                        if (retry_hit) begin
                            state_d = StHalt;
                            ufail_d = 1'b1;
                        end else begin
                            state_d = StRecover;
                            recov_d = 1'b1;
                        end
                    end else begin
                        fetch_d   = 1'b1;
                        retry_clr = 1'b1;
                        if (userFetch) begin
                            mode_d = norm_mode(userMode);
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            StRecover: begin
                phase_d = '0;
                if (rec_done) begin
                    state_d = StRun;
                end else begin
                    recov_d = 1'b1;
                end
            end
            StHalt: begin
                ufail_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
        ready_d = (state_d == StIdle) ||
                  ((state_d == StRun) && (phase_d == PW'(nphases(mode_d) - 2'd1)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            mode_q  <= MODE_SIMPLEX;
            phase_q <= '0;
            ready_q <= 1'b1;
            fetch_q <= 1'b0;
            recov_q <= 1'b0;
            ufail_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            phase_q <= phase_d;
            ready_q <= ready_d;
            fetch_q <= fetch_d;
            recov_q <= recov_d;
            ufail_q <= ufail_d;
        end
    end

    dytr_sat_cnt #(.W(CNTW)) u_err_cnt (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (err_inc),
        .clr_i  (1'b0),
        .q_o    (errCnt)
    );

    dytr_sat_cnt #(.W(RW)) u_retry_cnt (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (retry_inc),
        .clr_i  (retry_clr),
        .q_o    (retry_q)
    );

    dytr_sat_cnt #(.W(CW)) u_rec_cnt (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (in_rec),
        .clr_i  (!in_rec),
        .q_o    (rec_q)
    );

    assign userReady = ready_q;
    assign modeS     = mode_q;
    assign phase     = phase_q;
    assign fetchA    = fetch_q;
    assign recov     = recov_q;
    assign userFail  = ufail_q;

endmodule

// File: tb/tb_ctr_dyn_tr.sv
// Directed bench for ctr_dyn_tr: a default instance plus a 2-bit error-counter
// instance sharing the same stimulus.
module tb_ctr_dyn_tr;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] userMode = 2'b00;
    logic       userFetch = 1'b0;
    logic       fail = 1'b0;

    logic       rdy_a, fa_a, rc_a, uf_a;
    logic [1:0] ms_a, ph_a;
    logic [7:0] err_a;
    logic       rdy_b, fa_b, rc_b, uf_b;
    logic [1:0] ms_b, ph_b;
    logic [1:0] err_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ctr_dyn_tr dut (
        .clk       (clk),
        .reset     (reset),
        .userMode  (userMode),
        .userFetch (userFetch),
        .fail      (fail),
        .userReady (rdy_a),
        .modeS     (ms_a),
        .phase     (ph_a),
        .fetchA    (fa_a),
        .recov     (rc_a),
        .userFail  (uf_a),
        .errCnt    (err_a)
    );

    ctr_dyn_tr #(.CNTW(2)) dut_s (
        .clk       (clk),
        .reset     (reset),
        .userMode  (userMode),
        .userFetch (userFetch),
        .fail      (fail),
        .userReady (rdy_b),
        .modeS     (ms_b),
        .phase     (ph_b),
        .fetchA    (fa_b),
        .recov     (rc_b),
        .userFail  (uf_b),
        .errCnt    (err_b)
    );

    typedef struct {
        int mode; int fetch; int fl;
        int rdy; int ms; int ph; int fa; int rc; int uf; int err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(int mode, int fetch, int fl, int rdy, int ms, int ph,
                               int fa, int rc, int uf, int err);
        vec_t r;
        r.mode = mode; r.fetch = fetch; r.fl = fl;
        r.rdy = rdy; r.ms = ms; r.ph = ph; r.fa = fa; r.rc = rc; r.uf = uf; r.err = err;
        return r;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(string tag, int rdy, int ms, int ph, int fa, int rc, int uf,
                           int err);
        int err_sat;
        err_sat = (err > 3) ? 3 : err;
        chk({tag, " userReady"}, int'(rdy_a), rdy);
        chk({tag, " modeS"},     int'(ms_a),  ms);
        chk({tag, " phase"},     int'(ph_a),  ph);
        chk({tag, " fetchA"},    int'(fa_a),  fa);
        chk({tag, " recov"},     int'(rc_a),  rc);
        chk({tag, " userFail"},  int'(uf_a),  uf);
        chk({tag, " errCnt"},    int'(err_a), err);
        chk({tag, " s.userReady"}, int'(rdy_b), rdy);
        chk({tag, " s.phase"},     int'(ph_b),  ph);
        chk({tag, " s.fetchA"},    int'(fa_b),  fa);
        chk({tag, " s.recov"},     int'(rc_b),  rc);
        chk({tag, " s.userFail"},  int'(uf_b),  uf);
        chk({tag, " s.errCnt"},    int'(err_b), err_sat);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // mode fetch fail | rdy modeS phase fetchA recov userFail errCnt
        // back-to-back SIMPLEX, DUAL, TRIPLE; mid-operand mode changes ignored
        tbl.push_back(v(0, 1, 0,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 0,  0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(v(2, 1, 0,  1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(2, 1, 0,  0, 2, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0,  0, 2, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0,  1, 2, 2, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0,  1, 2, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0,  1, 2, 0, 0, 0, 0, 0));
        // TRIPLE via code 11, fail on phase 0 ignored, fail on phase 2 corrected
        tbl.push_back(v(3, 1, 0,  0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1,  0, 2, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0,  1, 2, 2, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1,  1, 2, 0, 1, 0, 0, 1));
        tbl.push_back(v(0, 0, 0,  1, 2, 0, 0, 0, 0, 1));
        // DUAL single fail, coinciding with userFetch: fail wins, 2-cycle rollback
        tbl.push_back(v(1, 1, 0,  0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(v(1, 0, 1,  1, 1, 1, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 1,  0, 1, 0, 0, 1, 0, 2));
        tbl.push_back(v(0, 1, 0,  0, 1, 0, 0, 1, 0, 2));
        tbl.push_back(v(0, 1, 0,  0, 1, 0, 0, 0, 0, 2));
        tbl.push_back(v(0, 0, 0,  1, 1, 1, 0, 0, 0, 2));
        tbl.push_back(v(0, 0, 0,  1, 1, 0, 1, 0, 0, 2));
        // DUAL persistent fail: third failure halts
        tbl.push_back(v(1, 1, 0,  0, 1, 0, 0, 0, 0, 2));
        tbl.push_back(v(1, 0, 0,  1, 1, 1, 0, 0, 0, 2));
        tbl.push_back(v(1, 0, 1,  0, 1, 0, 0, 1, 0, 3));
        tbl.push_back(v(0, 0, 0,  0, 1, 0, 0, 1, 0, 3));
        tbl.push_back(v(0, 0, 0,  0, 1, 0, 0, 0, 0, 3));
        tbl.push_back(v(0, 0, 0,  1, 1, 1, 0, 0, 0, 3));
        tbl.push_back(v(0, 0, 1,  0, 1, 0, 0, 1, 0, 4));
        tbl.push_back(v(0, 0, 0,  0, 1, 0, 0, 1, 0, 4));
        tbl.push_back(v(0, 0, 0,  0, 1, 0, 0, 0, 0, 4));
        tbl.push_back(v(0, 0, 0,  1, 1, 1, 0, 0, 0, 4));
        tbl.push_back(v(0, 1, 1,  0, 1, 0, 0, 0, 1, 5));

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            userMode  = 2'($urandom_range(0, 3));
            userFetch = 1'($urandom_range(0, 1));
            fail      = 1'($urandom_range(0, 1));
            step();
            chk_all("reset", 1, 0, 0, 0, 0, 0, 0);
        end
        userMode = 2'b00; userFetch = 1'b0; fail = 1'b0;
        reset = 1'b1;
        step();
        chk_all("post-reset idle", 1, 0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            userMode  = 2'(tbl[i].mode);
            userFetch = 1'(tbl[i].fetch);
            fail      = 1'(tbl[i].fl);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].ms, tbl[i].ph,
                    tbl[i].fa, tbl[i].rc, tbl[i].uf, tbl[i].err);
        end

        // HALT is sticky under arbitrary stimulus
        for (int i = 0; i < 20; i++) begin
            userMode  = 2'($urandom_range(0, 3));
            userFetch = 1'($urandom_range(0, 1));
            fail      = 1'($urandom_range(0, 1));
            step();
            chk_all("halt", 0, 1, 0, 0, 0, 1, 5);
        end

        // Asynchronous reset clears HALT without a clock edge
        reset = 1'b0;
        #1;
        chk_all("async reset halt", 1, 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b1;

        // Reset mid-RECOVER
        userMode = 2'b01; userFetch = 1'b1; fail = 1'b0;
        step();
        chk_all("rr accept", 0, 1, 0, 0, 0, 0, 0);
        userFetch = 1'b0;
        step();
        chk_all("rr phase1", 1, 1, 1, 0, 0, 0, 0);
        fail = 1'b1;
        step();
        chk_all("rr recover", 0, 1, 0, 0, 1, 0, 1);
        reset = 1'b0;
        fail = 1'b0;
        #1;
        chk_all("rr async clear", 1, 0, 0, 0, 0, 0, 0);
        step();
        chk_all("rr held", 1, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all("rr no spurious fetch", 1, 0, 0, 0, 0, 0, 0);
        end

        // Six corrected TRIPLE fails: default counter reaches 6, 2-bit one sticks at 3
        userMode = 2'b10; userFetch = 1'b1; fail = 1'b0;
        step();
        for (int k = 0; k < 6; k++) begin
            step();
            step();
            fail = 1'b1;
            userFetch = (k < 5);
            step();
            fail = 1'b0;
            chk("sat fetchA", int'(fa_a), 1);
            chk("sat recov", int'(rc_a), 0);
            chk("sat errCnt", int'(err_a), k + 1);
            chk("sat s.errCnt", int'(err_b), (k + 1 > 3) ? 3 : k + 1);
        end
        step();
        chk_all("sat final", 1, 2, 0, 0, 0, 0, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
